// File: rtl/alu_pkg.sv
// Shared opcodes and scheduler state encodings
// for the ALU operation scheduler.
package alu_pkg;

  localparam logic [2:0] OP_NOT  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_DIV  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  function automatic logic is_alu_op(
    input logic [2:0] op
  );
    return op <= OP_SUB;
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) and
// restoring divide, one bit per cycle.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ITER_CYC = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW =
    (ITER_CYC > 1) ? $clog2(ITER_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(ITER_CYC - 1);

  logic             r_busy;
  logic             r_div;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_opd;

  logic [WIDTH:0]   w_rem_sh;
  logic             w_fits;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_sh_nxt;

  // acc: product / remainder, sh: multiplier / dividend->quotient
  always_comb begin
    w_rem_sh  = {r_acc, r_sh[WIDTH-1]};
    w_fits    = (w_rem_sh >= {1'b0, r_opd});
    w_acc_nxt = {r_acc[WIDTH-2:0], 1'b0}
              + (r_sh[WIDTH-1] ? r_opd : '0);
    w_sh_nxt  = {r_sh[WIDTH-2:0], 1'b0};
    if (r_div) begin
      w_acc_nxt = w_fits
                ? (w_rem_sh[WIDTH-1:0] - r_opd)
                : w_rem_sh[WIDTH-1:0];
      w_sh_nxt  = {r_sh[WIDTH-2:0], w_fits};
    end
  end

  assign busy   = r_busy;
  assign done   = r_busy & (r_cnt == CNT_LAST);
  assign result = r_div ? w_sh_nxt : w_acc_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_div  <= 1'b0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_sh   <= '0;
      r_opd  <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_div  <= is_div;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_sh   <= is_div ? a : b;
      r_opd  <= is_div ? b : a;
    end else if (r_busy) begin
      r_acc <= w_acc_nxt;
      r_sh  <= w_sh_nxt;
      if (done) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Round-robin scheduler sharing one ALU and an
// iterative MUL/DIV unit between two requesters.
module alu_op_scheduler
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ITER_CYC = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             rsp_err
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rr;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_err;

  logic             w_any;
  logic             w_both;
  logic             w_gnt;
  logic             w_accept;
  logic [WIDTH-1:0] w_in_a;
  logic [WIDTH-1:0] w_in_b;
  logic [2:0]       w_in_op;
  logic             w_in_alu;
  logic             w_in_iter;
  logic             w_in_err;

  logic             w_md_busy;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_result;

  always_comb begin
    w_any     = req0_valid | req1_valid;
    w_both    = req0_valid & req1_valid;
    w_gnt     = w_both ? r_rr : req1_valid;
    w_accept  = rst_n & (r_state == ST_IDLE)
              & w_any;
    w_in_a    = w_gnt ? req1_a  : req0_a;
    w_in_b    = w_gnt ? req1_b  : req0_b;
    w_in_op   = w_gnt ? req1_op : req0_op;
    w_in_alu  = is_alu_op(w_in_op);
    w_in_iter = (w_in_op == OP_MUL)
              | ((w_in_op == OP_DIV)
                 & (w_in_b != '0));
    w_in_err  = ~w_in_alu & ~w_in_iter;
  end

  assign req0_ready = w_accept & ~w_gnt;
  assign req1_ready = w_accept &  w_gnt;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          unique case (1'b1)
            w_in_alu:  w_state_nxt = ST_EXEC;
            w_in_iter: w_state_nxt = ST_ITER;
            default:   w_state_nxt = ST_RESP;
          endcase
        end
      end
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_ITER: begin
        if (w_md_done | ~w_md_busy)
          w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rr       <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= OP_NOT;
      r_id       <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a  <= w_in_a;
        r_b  <= w_in_b;
        r_op <= w_in_op;
        r_id <= w_gnt;
        if (w_both)
          r_rr <= ~w_gnt;
        // error results skip execution entirely
        if (w_in_err) begin
          r_rsp_data <= (w_in_op == OP_RSVD)
                      ? '0 : '1;
          r_rsp_err  <= 1'b1;
        end
      end
      if (r_state == ST_EXEC) begin
        r_rsp_data <= alu_result;
        r_rsp_err  <= 1'b0;
      end
      if ((r_state == ST_ITER)
          && (w_state_nxt == ST_RESP)) begin
        r_rsp_data <= w_md_result;
        r_rsp_err  <= 1'b0;
      end
    end
  end

  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_op    = r_op;
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_id;
  assign rsp_err   = r_rsp_err;

  alu_iter_muldiv #(
    .WIDTH    (WIDTH),
    .ITER_CYC (ITER_CYC)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (w_accept & w_in_iter),
    .is_div (w_in_op == OP_DIV),
    .a      (w_in_a),
    .b      (w_in_b),
    .busy   (w_md_busy),
    .done   (w_md_done),
    .result (w_md_result)
  );

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Randomized self-checking bench for
// alu_op_scheduler with its own reference model.
module tb_alu_op_scheduler;

  localparam logic [2:0] T_NOT = 3'd0;
  localparam logic [2:0] T_AND = 3'd1;
  localparam logic [2:0] T_ADD = 3'd3;
  localparam logic [2:0] T_SUB = 3'd4;
  localparam logic [2:0] T_MUL = 3'd5;
  localparam logic [2:0] T_DIV = 3'd6;
  localparam logic [2:0] T_RSV = 3'd7;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [2:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [2:0]  req1_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_id, rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  alu_op_scheduler #(.WIDTH(32), .ITER_CYC(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external combinational ALU
  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      3'd0: alu_result = ~alu_a;
      3'd1: alu_result = alu_a & alu_b;
      3'd2: alu_result = alu_a | alu_b;
      3'd3: alu_result = alu_a + alu_b;
      3'd4: alu_result = alu_a - alu_b;
      default: alu_result = 32'd0;
    endcase
  end

  function automatic void ref_op(
    input  logic [2:0]  op,
    input  logic [31:0] a, b,
    output logic [31:0] d,
    output logic        e,
    output int          lat
  );
    logic [63:0] p;
    e = 1'b0; lat = 2; d = 32'd0;
    case (op)
      3'd0: d = ~a;
      3'd1: d = a & b;
      3'd2: d = a | b;
      3'd3: d = a + b;
      3'd4: d = a - b;
      3'd5: begin
        p = {32'd0, a} * {32'd0, b};
        d = p[31:0]; lat = 33;
      end
      3'd6: begin
        if (b == 0) begin
          d = 32'hFFFF_FFFF; e = 1'b1; lat = 1;
        end else begin
          d = a / b; lat = 33;
        end
      end
      default: begin d = 32'd0; e = 1'b1; lat = 1; end
    endcase
  endfunction

  task automatic do_op(
    input  logic        id,
    input  logic [2:0]  op,
    input  logic [31:0] a, b,
    output logic [31:0] d,
    output logic        e,
    output logic        rid,
    output int          lat,
    output bit          tout
  );
    bit acc;
    tout = 0; acc = 0; lat = 0;
    d = '0; e = 0; rid = 0;
    @(negedge clk);
    rsp_ready = 1'b1;
    if (id) begin
      req1_valid = 1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1; req0_op = op; req0_a = a; req0_b = b;
    end
    for (int n = 0; n < 20 && !acc; n++) begin
      #1;
      acc = id ? req1_ready : req0_ready;
      if (!acc) @(negedge clk);
    end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    if (!acc) begin tout = 1; return; end
    lat = 1;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (rsp_valid) break;
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      tout = 1;
    end else begin
      d = rsp_data; e = rsp_err; rid = rsp_id;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0; rsp_ready = 0;
    req0_valid = 1; req0_op = T_ADD; req0_a = 3; req0_b = 4;
    req1_valid = 1; req1_op = T_AND; req1_a = 1; req1_b = 1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b want 000",
               {req0_ready, req1_ready, rsp_valid});
    end
    n_cmp++;
    if ({rsp_data, rsp_id, rsp_err} !== 34'd0) begin
      n_bad++;
      $display("FAIL reset_rsp: got %h/%b/%b want 0/0/0",
               rsp_data, rsp_id, rsp_err);
    end
    n_cmp++;
    if ({alu_a, alu_b, alu_op} !== 67'd0) begin
      n_bad++;
      $display("FAIL reset_alu: got %h/%h/%h want 0",
               alu_a, alu_b, alu_op);
    end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0; rst_n = 1;
  endtask

  task automatic test_round_robin();
    logic [31:0] qd[$];
    logic        qid[$];
    logic [31:0] ed;
    logic        gid;
    int ng;
    bit ptr, g0, g1;
    ptr = 0; ng = 0; g0 = 0; g1 = 0;
    @(negedge clk);
    rsp_ready = 1;
    req0_valid = 1; req0_op = T_AND;
    req0_a = $urandom; req0_b = $urandom;
    req1_valid = 1; req1_op = T_AND;
    req1_a = $urandom; req1_b = $urandom;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (rsp_valid) begin
        n_cmp++;
        if (qd.size() == 0) begin
          n_bad++;
          $display("FAIL rr_extra_rsp: got %h want none", rsp_data);
        end else begin
          ed = qd.pop_front(); gid = qid.pop_front();
          if (rsp_data !== ed || rsp_id !== gid) begin
            n_bad++;
            $display("FAIL rr_rsp: got %h id %b want %h id %b",
                     rsp_data, rsp_id, ed, gid);
          end
        end
      end
      if (req0_ready || req1_ready) begin
        n_cmp++;
        if ((req0_ready && req1_ready) || req1_ready !== ptr) begin
          n_bad++;
          $display("FAIL rr_grant%0d: got r0=%b r1=%b want port %0d",
                   ng, req0_ready, req1_ready, ptr);
        end
        if (req1_ready) begin
          qd.push_back(req1_a & req1_b); qid.push_back(1'b1); g1 = 1;
        end else begin
          qd.push_back(req0_a & req0_b); qid.push_back(1'b0); g0 = 1;
        end
        ptr = !req1_ready;
        ng++;
      end
      if (ng >= 4 && qd.size() == 0) break;
      @(negedge clk);
      if (ng >= 4) begin req0_valid = 0; req1_valid = 0; end
      if (g0) begin req0_a = $urandom; req0_b = $urandom; g0 = 0; end
      if (g1) begin req1_a = $urandom; req1_b = $urandom; g1 = 0; end
    end
    n_cmp++;
    if (ng != 4 || qd.size() != 0) begin
      n_bad++;
      $display("FAIL rr_count: got %0d grants %0d pending want 4 0",
               ng, qd.size());
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic check_op(
    input string       nm,
    input logic        id,
    input logic [2:0]  op,
    input logic [31:0] a, b
  );
    logic [31:0] d, ed;
    logic e, ee, rid;
    int lat, el;
    bit tout;
    ref_op(op, a, b, ed, ee, el);
    do_op(id, op, a, b, d, e, rid, lat, tout);
    n_cmp++;
    if (tout || d !== ed || e !== ee || rid !== id || lat != el) begin
      n_bad++;
      $display("FAIL %s: got d=%h e=%b id=%b lat=%0d to=%0d want d=%h e=%b id=%b lat=%0d",
               nm, d, e, rid, lat, tout, ed, ee, id, el);
    end
  endtask

  task automatic test_add();
    check_op("add_5_7", 1'b0, T_ADD, 32'd5, 32'd7);
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL add_valid_drop: got %b want 0", rsp_valid);
    end
    check_op("sub_wrap", 1'b1, T_SUB, 32'd3, 32'd9);
    check_op("not", 1'b0, T_NOT, 32'h1234_5678, 32'd0);
  endtask

  task automatic test_mul();
    check_op("mul_req1", 1'b1, T_MUL, 32'h0001_0000, 32'h0001_0003);
    check_op("mul_max", 1'b0, T_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic test_div();
    check_op("div_100_7", 1'b0, T_DIV, 32'd100, 32'd7);
    check_op("div_by_0", 1'b0, T_DIV, 32'd9, 32'd0);
    check_op("div_big", 1'b1, T_DIV, 32'hFFFF_FFFF, 32'd1);
    check_op("rsvd", 1'b1, T_RSV, 32'd77, 32'd5);
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        id;
    for (int i = 0; i < 24; i++) begin
      id = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 1000));
        default: b = $urandom;
      endcase
      check_op("random", id, op, a, b);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ea, eb, ex;
    bit seen;
    ea = $urandom; eb = $urandom; ex = ea + eb;
    @(negedge clk);
    rsp_ready = 0;
    req0_valid = 1; req0_op = T_ADD; req0_a = ea; req0_b = eb;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_accept: got %b want 1", req0_ready);
    end
    @(negedge clk);
    req0_valid = 0;
    req1_valid = 1; req1_op = T_SUB; req1_a = 32'd50; req1_b = 32'd8;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1;
      seen = rsp_valid;
      if (!seen) @(negedge clk);
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL bp_rsp_timeout: got none want rsp_valid");
    end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_err, req0_ready, req1_ready} !== 5'b10000
          || rsp_data !== ex) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got v%b id%b e%b r%b%b d=%h want 10000 d=%h",
                 i, rsp_valid, rsp_id, rsp_err, req0_ready, req1_ready,
                 rsp_data, ex);
      end
      @(negedge clk);
      #1;
    end
    rsp_ready = 1;
    #1;
    n_cmp++;
    if (req1_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_hs_ready: got %b want 0", req1_ready);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_next_accept: got v%b r1=%b want v0 r1=1",
               rsp_valid, req1_ready);
    end
    @(negedge clk);
    req1_valid = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1;
      seen = rsp_valid;
      if (!seen) @(negedge clk);
    end
    n_cmp++;
    if (!seen || rsp_data !== 32'd42 || rsp_id !== 1'b1 || rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_second: got v%b d=%h id%b e%b want 1 0000002a 1 0",
               seen, rsp_data, rsp_id, rsp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    bit spur;
    @(negedge clk);
    rsp_ready = 1;
    req0_valid = 1; req0_op = T_DIV;
    req0_a = $urandom; req0_b = $urandom | 32'd1;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_accept: got %b want 1", req0_ready);
    end
    @(negedge clk);
    req0_valid = 0;
    repeat (9) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_data, rsp_id, rsp_err, req0_ready, req1_ready,
         alu_a, alu_b, alu_op} !== 104'd0) begin
      n_bad++;
      $display("FAIL abort_zero: got v%b d=%h id%b e%b a=%h b=%h op=%h want 0",
               rsp_valid, rsp_data, rsp_id, rsp_err, alu_a, alu_b, alu_op);
    end
    @(negedge clk);
    rst_n = 1;
    spur = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) spur = 1;
    end
    n_cmp++;
    if (spur) begin
      n_bad++;
      $display("FAIL abort_no_rsp: got rsp_valid 1 want 0");
    end
    check_op("abort_add", 1'b0, T_ADD, 32'd1, 32'd1);
  endtask

  initial begin
    rst_n = 0; rsp_ready = 0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    test_reset();
    test_round_robin();
    test_add();
    test_mul();
    test_div();
    test_random();
    test_backpressure();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
